// File: rtl/sync_updn_cntr.sv
// sync_updn_cntr: modulo-MODULUS up/down counter with saturate/wrap modes, load, preset, clear and sticky overflow.
module sync_updn_cntr #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             pre,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH:0]   cnt;
  logic [WIDTH-1:0] out_nxt;
  logic             at_lim, wrap_nxt, ovf_nxt;
  assign cnt    = {1'b0, out};
  assign at_lim = up ? (out == MAX) : (out == '0);
  assign tc     = en & at_lim;
  // One step past a limit either wraps or is blocked; both mark the sticky flag.
  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    if (clr) begin
      out_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (pre) begin
      out_nxt = MAX;
    end else if (ld) begin
      out_nxt = (din > MAX) ? MAX : din;
    end else if (en) begin
      if (at_lim) begin
        ovf_nxt  = 1'b1;
        wrap_nxt = ~sat;
        out_nxt  = sat ? out : (up ? '0 : MAX);
      end else begin
        out_nxt = up ? WIDTH'(cnt + 1'b1) : WIDTH'(cnt - 1'b1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      out  <= out_nxt;
      wrap <= wrap_nxt;
      ovf  <= ovf_nxt;
    end
  end
endmodule

// File: doc/sync_updn_cntr.md
SYNC_UPDN_CNTR -- requirements
Module: sync_updn_cntr

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..16.
REQ-002 Parameter MODULUS, default 16: count sequence length; legal range 2..2^WIDTH; count range 0..MODULUS-1.
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 En  input  1  count enable.
REQ-006 Up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 Sat  input  1  mode: 1 = saturate at the range limits, 0 = wrap modulo MODULUS.
REQ-008 Ld  input  1  synchronous parallel load of Din.
REQ-009 Din  input  WIDTH  load value.
REQ-010 Pre  input  1  synchronous preset to MODULUS-1.
REQ-011 Clr  input  1  synchronous clear of the count and the sticky flag.
REQ-012 Out  output  WIDTH  current count, registered.
REQ-013 Tc  output  1  terminal count, combinational: high when En=1 and Out is at the limit for the current direction (Up=1: MODULUS-1; Up=0: 0).
REQ-014 Wrap  output  1  registered one-cycle pulse; high in the cycle after a wrap occurred.
REQ-015 Ovf  output  1  sticky flag; set by any wrap or blocked saturating step; cleared only by Clr or reset.

Function
REQ-016 Synchronous controls SHALL have fixed priority per edge: Clr > Pre > Ld > En; only the highest active control acts.
REQ-017 Clr SHALL set Out=0 and Ovf=0, with Wrap=0 on the next cycle.
REQ-018 Pre SHALL set Out=MODULUS-1; Ovf is unchanged and Wrap=0.
REQ-019 Ld SHALL set Out=Din when Din<=MODULUS-1, otherwise Out=MODULUS-1 (clamp); Ovf is unchanged and Wrap=0.
REQ-020 With En=1 and no higher control active, the counter SHALL step by exactly one per edge in the direction given by Up; latency is one clock from the sampled En to the updated Out.
REQ-021 With En=0 and no control active, Out SHALL hold and Wrap SHALL be 0.
REQ-022 Sat=0, Up=1, Out=MODULUS-1, stepping: Out SHALL become 0, Wrap SHALL pulse and Ovf SHALL set.
REQ-023 Sat=0, Up=0, Out=0, stepping: Out SHALL become MODULUS-1, Wrap SHALL pulse and Ovf SHALL set.
REQ-024 Sat=1 at the limit for the current direction: Out SHALL hold, Wrap SHALL stay 0 and Ovf SHALL set.
REQ-025 Internal arithmetic SHALL use WIDTH+1 bits; no intermediate value may alias when MODULUS=2^WIDTH.
REQ-026 Up and Sat SHALL be sampled every edge; changing them between edges is legal and takes effect on the next step.
REQ-027 Out SHALL never leave 0..MODULUS-1 under any input sequence.
REQ-028 Tc SHALL be the only combinational output and SHALL depend only on Out, Up and En.

Reset
REQ-029 rst=0 SHALL immediately force Out=0, Wrap=0 and Ovf=0, independent of Clk.
REQ-030 Assertion of rst mid-count or mid-load SHALL take effect immediately; no partial update may be visible.
REQ-031 After rst deasserts, the first state change SHALL occur on the first rising Clk edge that sees rst=1.
REQ-032 Every output SHALL be defined (no X) during and after reset; Tc during reset follows REQ-013 with Out=0.

Verification
REQ-033 WIDTH=4, MODULUS=10, Sat=0, Up=1, En=1 from reset for 12 clocks -> Out runs 1..9,0,1,2; Wrap is high only in the cycle after the 9->0 step; Ovf=1 from that cycle on.
REQ-034 MODULUS=10, Sat=1, Up=0, Out=2, En=1 for 4 clocks -> Out runs 1,0,0,0; Wrap never rises; Ovf sets on the first blocked step.
REQ-035 MODULUS=10, Ld=1 with Din=13 -> Out=9; then Ld=1 with Din=4 and Pre=1 together -> Out=9 (Pre wins); then Clr=1, Pre=1 and Ld=1 together -> Out=0 and Ovf=0.
REQ-036 WIDTH=4, MODULUS=16, Sat=0, Up=0, En=1 from Out=0 -> Out=15 and Wrap pulses; Tc was high in the cycle before that edge.
REQ-037 Counting up with Out=6, rst pulsed low between Clk edges -> Out=0, Ovf=0 and Wrap=0 before the next edge; counting resumes 1,2,... after release.
REQ-038 Randomised control sequence over 10k cycles, MODULUS=10 -> Out stays within 0..9 throughout and matches a reference model every cycle.
